rec2pol_sched: RTL and testbench

- Two-requester round-robin scheduler that shares one rec2pol CORDIC core.
- Accepts (x,y) jobs over valid/ready handshakes and latches the operands.
- Sequences the core's start/enable pins for a fixed iteration count, captures mod/angle, and returns a tagged response over a valid/ready handshake.
- Sits between client blocks and the rec2pol instance; it is the only driver of the core's start/enable pins.

---
 rtl/rec2pol_sched.sv | 209 ++++++++++++++++++++
 tb/tb_rec2pol_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec2pol_sched.sv
// Two-requester round-robin scheduler that time-shares one rec2pol CORDIC core.
// Optional build macro REC2POL_RANGE_CHECK_EN rejects out-of-range X operands without running the core.
module rec2pol_sched #(
    parameter int unsigned ITER_CYCLES = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_mod,
    output logic [31:0] rsp_angle,
    output logic        rsp_err,
    output logic        cor_start,
    output logic        cor_enable,
    output logic [31:0] cor_x,
    output logic [31:0] cor_y,
    input  logic [31:0] cor_mod,
    input  logic [31:0] cor_angle,
    output logic        busy
);
    localparam int unsigned     DW       = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cor_start_q, cor_start_d;
    logic              cor_enable_q, cor_enable_d;
    logic [DW-1:0]     cor_x_q, cor_x_d;
    logic [DW-1:0]     cor_y_q, cor_y_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DW-1:0]     rsp_mod_q, rsp_mod_d;
    logic [DW-1:0]     rsp_angle_q, rsp_angle_d;
    logic              busy_q, busy_d;

    logic              grant0, grant1;
    logic              accept, accept_id;
    logic [DW-1:0]     acc_x, acc_y;

    // A lone valid wins; on contention the requester not granted last time wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign accept_id  = req1_ready;
    assign acc_x      = accept_id ? req1_x : req0_x;
    assign acc_y      = accept_id ? req1_y : req0_y;

`ifdef REC2POL_RANGE_CHECK_EN
    localparam logic signed [DW-1:0] X_MAX = 32'sh7FFF_0000;
    logic range_bad;
    logic rsp_err_q, rsp_err_d;

    // The core only converges for strictly positive X below X_MAX.
    assign range_bad = !(($signed(acc_x) > 0) && ($signed(acc_x) < X_MAX));
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        cor_start_d  = 1'b0;
        cor_enable_d = cor_enable_q;
        cor_x_d      = cor_x_q;
        cor_y_d      = cor_y_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_mod_d    = rsp_mod_q;
        rsp_angle_d  = rsp_angle_q;
`ifdef REC2POL_RANGE_CHECK_EN
        rsp_err_d    = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cor_x_d      = acc_x;
                    cor_y_d      = acc_y;
                    owner_d      = accept_id;
                    last_grant_d = accept_id;
`ifdef REC2POL_RANGE_CHECK_EN
                    if (range_bad) begin
                        // Rejected job: response is raised on the following cycle in RESP.
                        state_d     = RESP;
                        rsp_id_d    = accept_id;
                        rsp_mod_d   = '0;
                        rsp_angle_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d      = START;
                        cor_start_d  = 1'b1;
                        cor_enable_d = 1'b1;
                    end
`else
                    state_d      = START;
                    cor_start_d  = 1'b1;
                    cor_enable_d = 1'b1;
`endif
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cor_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = owner_q;
                    rsp_mod_d    = cor_mod;
                    rsp_angle_d  = cor_angle;
`ifdef REC2POL_RANGE_CHECK_EN
                    rsp_err_d    = 1'b0;
`endif
                    state_d      = RESP;
                end
            end
            RESP: begin
                cor_enable_d = 1'b0;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
`ifdef REC2POL_RANGE_CHECK_EN
                else if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            cor_start_q  <= 1'b0;
            cor_enable_q <= 1'b0;
            cor_x_q      <= '0;
            cor_y_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_mod_q    <= '0;
            rsp_angle_q  <= '0;
            busy_q       <= 1'b0;
`ifdef REC2POL_RANGE_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            cor_start_q  <= cor_start_d;
            cor_enable_q <= cor_enable_d;
            cor_x_q      <= cor_x_d;
            cor_y_q      <= cor_y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_mod_q    <= rsp_mod_d;
            rsp_angle_q  <= rsp_angle_d;
            busy_q       <= busy_d;
`ifdef REC2POL_RANGE_CHECK_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign cor_start  = cor_start_q;
    assign cor_enable = cor_enable_q;
    assign cor_x      = cor_x_q;
    assign cor_y      = cor_y_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_mod    = rsp_mod_q;
    assign rsp_angle  = rsp_angle_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rec2pol_sched.sv
// Bench for rec2pol_sched: stand-in CORDIC core, cycle-count reference model and directed scenarios.
module tb_rec2pol_sched;
    localparam int unsigned ITER = 32;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_mod, rsp_angle;
    logic        cor_start, cor_enable, busy;
    logic [31:0] cor_x, cor_y, cor_mod, cor_angle;

    int checks   = 0;
    int failures = 0;

    rec2pol_sched #(.ITER_CYCLES(ITER), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_mod(rsp_mod), .rsp_angle(rsp_angle), .rsp_err(rsp_err),
        .cor_start(cor_start), .cor_enable(cor_enable), .cor_x(cor_x), .cor_y(cor_y),
        .cor_mod(cor_mod), .cor_angle(cor_angle), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in core results: 3-4-5 triangle gives the true answer, other operands a distinct signature.
    function automatic logic [31:0] fmod(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h0003_0000 && y == 32'h0004_0000) return 32'h0005_0000;
        return x + y;
    endfunction

    function automatic logic [31:0] fang(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h0003_0000 && y == 32'h0004_0000) return 32'h3512_5D00;
        return x ^ y ^ 32'h1234_5678;
    endfunction

`ifdef REC2POL_RANGE_CHECK_EN
    function automatic bit in_range(input logic [31:0] x);
        return ($signed(x) > 0) && ($signed(x) < $signed(32'h7FFF_0000));
    endfunction
`endif

    // Core: result is only final after ITER-1 enabled cycles beyond the start cycle, junk otherwise.
    logic [31:0] cx, cy, it;
    always @(posedge clock) begin
        if (reset) it <= 32'd0;
        else if (cor_start) begin
            cx <= cor_x;
            cy <= cor_y;
            it <= 32'd0;
        end else if (cor_enable) it <= it + 32'd1;
    end
    assign cor_mod   = (it == ITER - 1) ? fmod(cx, cy) : 32'hBAD0_0000 + it;
    assign cor_angle = (it == ITER - 1) ? fang(cx, cy) : 32'hBEE0_0000 + it;

    // Reference model: t counts clock edges since the accepting edge.
    bit          known = 1'b0;
    bit          mbusy, mrej, mlast, mown, mvalid, mid, merr, g0, g1, en_exp;
    int unsigned t;
    logic [31:0] mx, my, mmod, mang;

    initial begin
        forever begin
            @(negedge clock);
            g0 = req0_valid && (!req1_valid || mlast);
            g1 = req1_valid && (!req0_valid || !mlast);
            if (known) begin
                en_exp = mbusy && !mrej && t >= 1 && t <= ITER + 1;
                chk("req0_ready", 32'(req0_ready), 32'(!mbusy && g0));
                chk("req1_ready", 32'(req1_ready), 32'(!mbusy && g1));
                chk("busy", 32'(busy), 32'(mbusy));
                chk("cor_start", 32'(cor_start), 32'(mbusy && !mrej && t == 1));
                chk("cor_enable", 32'(cor_enable), 32'(en_exp));
                chk("rsp_valid", 32'(rsp_valid), 32'(mvalid));
                if (en_exp) begin
                    chk("cor_x", cor_x, mx);
                    chk("cor_y", cor_y, my);
                end
                if (mvalid) begin
                    chk("rsp_id", 32'(rsp_id), 32'(mid));
                    chk("rsp_mod", rsp_mod, mmod);
                    chk("rsp_angle", rsp_angle, mang);
                    chk("rsp_err", 32'(rsp_err), 32'(merr));
                end
            end
            if (reset) begin
                known = 1'b1; mbusy = 1'b0; mvalid = 1'b0; mlast = 1'b1; mrej = 1'b0; t = 0;
            end else if (known) begin
                if (!mbusy) begin
                    if (g0 || g1) begin
                        mown  = g1;
                        mlast = g1;
                        mx    = g1 ? req1_x : req0_x;
                        my    = g1 ? req1_y : req0_y;
`ifdef REC2POL_RANGE_CHECK_EN
                        mrej  = !in_range(mx);
`else
                        mrej  = 1'b0;
`endif
                        mbusy = 1'b1;
                        t     = 1;
                    end
                end else if (mvalid && rsp_ready) begin
                    mvalid = 1'b0; mbusy = 1'b0; t = 0;
                end else begin
                    t++;
                    if (!mvalid && ((!mrej && t == ITER + 2) || (mrej && t == 2))) begin
                        mvalid = 1'b1;
                        mid    = mown;
                        merr   = mrej;
                        mmod   = mrej ? 32'h0 : fmod(mx, my);
                        mang   = mrej ? 32'h0 : fang(mx, my);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Returns just after the edge that accepts requester r.
    task automatic wait_accept(input int r);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (r == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                step();
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // n = index of the first negedge (1 = cycle after the accept edge) showing rsp_valid.
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            n++;
            if (rsp_valid) return;
        end
        chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    int n, nrsp, i0, i1;
    int ids[4];
    bit a0, a1;

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        step(); step();
        reset = 1'b0;

        // Reset values
        @(negedge clock);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_mod", rsp_mod, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_cor_x", cor_x, 32'd0);
        chk("rst_cor_enable", 32'(cor_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();

        // 3-4-5 job on requester 0
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_x = 32'h0003_0000; req0_y = 32'h0004_0000;
        wait_accept(0);
        req0_valid = 1'b0;
        wait_rsp(n);
        chk("t1_latency", 32'(n), 32'd34);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_mod", rsp_mod, 32'h0005_0000);
        chk("t1_angle", rsp_angle, 32'h3512_5D00);
        step();

        // Both requesters permanently valid: grants alternate starting with 0
        do_reset();
        req0_valid = 1'b1; req0_x = 32'h0001_0000; req0_y = 32'h0002_0000;
        req1_valid = 1'b1; req1_x = 32'h000A_0000; req1_y = 32'h0003_0000;
        nrsp = 0; i0 = 0; i1 = 0;
        for (int c = 0; c < 600 && nrsp < 4; c++) begin
            @(negedge clock);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (rsp_valid && rsp_ready) begin
                ids[nrsp] = int'(rsp_id);
                nrsp++;
            end
            step();
            if (a0) begin i0++; req0_x = 32'((i0 + 1) << 16); end
            if (a1) begin i1++; req1_x = 32'((i1 + 10) << 16); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_count", 32'(nrsp), 32'd4);
        chk("t2_id0", 32'(ids[0]), 32'd0);
        chk("t2_id1", 32'(ids[1]), 32'd1);
        chk("t2_id2", 32'(ids[2]), 32'd0);
        chk("t2_id3", 32'(ids[3]), 32'd1);

        // Back-pressure on the response
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_x = 32'h0005_0000; req0_y = 32'h000C_0000;
        wait_accept(0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_x = 32'h0002_0000; req1_y = 32'h0006_0000;
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t3_hold_mod", rsp_mod, 32'h0011_0000);
            chk("t3_hold_angle", rsp_angle, 32'h123D_5678);
            chk("t3_hold_ready1", 32'(req1_ready), 32'd0);
            chk("t3_hold_busy", 32'(busy), 32'd1);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t3_next_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("t3_id", 32'(rsp_id), 32'd1);
        step();

        // Reset in the middle of RUN
        do_reset();
        req0_valid = 1'b1; req0_x = 32'h0007_0000; req0_y = 32'h0001_0000;
        wait_accept(0);
        req0_valid = 1'b0;
        repeat (10) step();
        do_reset();
        @(negedge clock);
        chk("t4_enable", 32'(cor_enable), 32'd0);
        chk("t4_valid", 32'(rsp_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        step();
        req1_valid = 1'b1; req1_x = 32'h0002_0000; req1_y = 32'h0003_0000;
        wait_accept(1);
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("t4_latency", 32'(n), 32'd34);
        chk("t4_id", 32'(rsp_id), 32'd1);
        chk("t4_mod", rsp_mod, 32'h0005_0000);
        chk("t4_angle", rsp_angle, 32'h1235_5678);
        step();

        // Negative X operand
        req1_valid = 1'b1; req1_x = 32'hFFFF_0000; req1_y = 32'h0002_0000;
        wait_accept(1);
        req1_valid = 1'b0;
        wait_rsp(n);
        chk("t5_id", 32'(rsp_id), 32'd1);
`ifdef REC2POL_RANGE_CHECK_EN
        chk("t5_latency", 32'(n), 32'd2);
        chk("t5_err", 32'(rsp_err), 32'd1);
        chk("t5_mod", rsp_mod, 32'd0);
`else
        chk("t5_latency", 32'(n), 32'd34);
        chk("t5_err", 32'(rsp_err), 32'd0);
        chk("t5_mod", rsp_mod, 32'h0001_0000);
        chk("t5_angle", rsp_angle, 32'hEDC9_5678);
`endif
        step();

        // Single-cycle req0 pulse while busy is ignored
        req1_valid = 1'b1; req1_x = 32'h0004_0000; req1_y = 32'h0004_0000;
        wait_accept(1);
        req1_valid = 1'b0;
        repeat (3) step();
        req0_valid = 1'b1; req0_x = 32'h0009_0000; req0_y = 32'h0009_0000;
        step();
        req0_valid = 1'b0;
        wait_rsp(n);
        chk("t6_id", 32'(rsp_id), 32'd1);
        chk("t6_mod", rsp_mod, 32'h0008_0000);
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
            chk("t6_idle", 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
